serial_slice_adder: RTL and testbench



---
 rtl/serial_slice_adder_pkg.sv | 12 +
 rtl/serial_slice_adder_adder3.sv | 21 ++
 rtl/serial_slice_adder.sv | 136 +++++++++++++
 tb/tb_serial_slice_adder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_slice_adder_pkg.sv
// Shared types and constants for the bit-serial (3-bit slice) adder.
package serial_slice_adder_pkg;

  localparam int SLICE_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

endpackage

// File: rtl/serial_slice_adder_adder3.sv
// adder3: 3-bit ripple-carry cell built from gate-level full adders.
module adder3 (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       cin,
  output logic [2:0] s,
  output logic       cout
);

  logic [3:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 3; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[3];

endmodule

// File: rtl/serial_slice_adder.sv
// Multi-cycle N-bit adder feeding one 3-bit slice per clock through adder3.
// Optional signed-overflow output enabled by SERIAL_SLICE_ADDER_OVF_EN.
module serial_slice_adder
  import serial_slice_adder_pkg::*;
#(
  parameter int N = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout
`ifdef SERIAL_SLICE_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int S     = N / SLICE_W;
  localparam int CNT_W = (S > 1) ? $clog2(S) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(S - 1);

  if ((N <= 0) || ((N % SLICE_W) != 0)) begin : g_bad_width
    $error("serial_slice_adder: N must be a positive multiple of 3");
  end

  state_t             state;
  state_t             state_nxt;
  logic [N-1:0]       a_sh;
  logic [N-1:0]       b_sh;
  logic [N-1:0]       sum_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic [SLICE_W-1:0] s_slice;
  logic               c_slice;
  logic [N+SLICE_W-1:0] sum_ext;

  // Control: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_ADD;
      end
      S_ADD: begin
        if (cnt == CNT_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  // Slice datapath: one adder3 evaluation per ADD cycle
  adder3 u_adder3 (
    .a    (a_sh[SLICE_W-1:0]),
    .b    (b_sh[SLICE_W-1:0]),
    .cin  (carry_q),
    .s    (s_slice),
    .cout (c_slice)
  );

  // New slice enters at the top; after S shifts slice k sits at bits 3k+2:3k.
  assign sum_ext = {s_slice, sum_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      carry_q <= cin;
      cnt     <= '0;
    end else if (state == S_ADD) begin
      sum_q   <= sum_ext[N+SLICE_W-1:SLICE_W];
      carry_q <= c_slice;
      cnt     <= cnt + 1'b1;
    end
  end

  // Operand shift registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= a;
      b_sh <= b;
    end else if (state == S_ADD) begin
      a_sh <= a_sh >> SLICE_W;
      b_sh <= b_sh >> SLICE_W;
    end
  end

  assign sum  = sum_q;
  assign cout = carry_q;

`ifdef SERIAL_SLICE_ADDER_OVF_EN
  logic a_sign;
  logic b_sign;

  function automatic logic ovf_detect(input logic sa, input logic sb, input logic ss);
    return (sa == sb) & (ss != sa);
  endfunction

  always_ff @(posedge clk) begin
    if (accept) begin
      a_sign <= a[N-1];
      b_sign <= b[N-1];
    end
  end

  // Only meaningful once all slices are in; forced low elsewhere, including reset.
  assign ovf = (state == S_DONE) & ovf_detect(a_sign, b_sign, sum_q[N-1]);
`endif

endmodule

// File: tb/tb_serial_slice_adder.sv
// Scoreboard bench for serial_slice_adder (N=12), directed cases plus random traffic.
module tb_serial_slice_adder;

  localparam int N = 12;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
`ifdef SERIAL_SLICE_ADDER_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic rand_ready = 1'b0;

  serial_slice_adder #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERIAL_SLICE_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic mc);
    exp_t r;
    int unsigned t;
    int sa, sbv, ss;
    t      = 32'(ma) + 32'(mb) + 32'(mc);
    r.sum  = t[N-1:0];
    r.cout = t[N];
    sa     = ma[N-1] ? int'(32'(ma)) - (1 << N) : int'(32'(ma));
    sbv    = mb[N-1] ? int'(32'(mb)) - (1 << N) : int'(32'(mb));
    ss     = sa + sbv + int'(32'(mc));
    r.ovf  = (ss > (1 << (N - 1)) - 1) || (ss < -(1 << (N - 1)));
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic ic);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got in_ready=0, required 1");
    end else begin
      in_valid = 1'b1;
      a = ia;
      b = ib;
      cin = ic;
      tick();
      in_valid = 1'b0;
      a = N'($urandom);
      b = N'($urandom);
      cin = 1'($urandom);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got out_valid=0, required 1");
    end
  endtask

  // Monitor: scoreboard push on accept, pop and compare on output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
      end else begin
        if (in_valid && in_ready) sb.push_back(model(a, b, cin));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got sum=0x%0h, required no result", sum);
          end else begin
            e = sb.pop_front();
            check("sum", 32'(sum), 32'(e.sum));
            check("cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_SLICE_ADDER_OVF_EN
            check("ovf", 32'(ovf), 32'(e.ovf));
`endif
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    exp_t hold_e;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_SLICE_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif

    // Latency: out_valid rises after edge E+4, in_ready low meanwhile.
    tick();
    issue(12'hFFF, 12'h001, 1'b0);
    for (int j = 0; j <= 4; j++) begin
      @(negedge clk);
      check("latency_out_valid", 32'(out_valid), (j == 4) ? 32'd1 : 32'd0);
      check("latency_in_ready", 32'(in_ready), 32'd0);
    end
    tick();
    drain(20);

    issue(12'h555, 12'h2AA, 1'b1);
    drain(20);

    // Backpressure with ignored in_valid pulses.
    hold_e = model(12'h123, 12'h456, 1'b0);
    issue(12'h123, 12'h456, 1'b0);
    wait_out_valid();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'($urandom_range(0, 1)) | (k == 0);
      a = 12'hABC;
      b = 12'h321;
      cin = 1'b1;
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_sum", 32'(sum), 32'(hold_e.sum));
      check("hold_cout", 32'(cout), 32'(hold_e.cout));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready_before", 32'(in_ready), 32'd0);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("release_in_ready_after", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 6; k++) tick();
    @(negedge clk);
    check("pulse_not_accepted", 32'(out_valid), 32'd0);
    check("pulse_no_pending", 32'(sb.size()), 32'd0);

    // Reset in the middle of ADD discards the partial result and carry.
    tick();
    issue(12'hFFF, 12'hFFF, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    tick();
    issue(12'h001, 12'h001, 1'b0);
    drain(20);

    issue(12'h800, 12'h800, 1'b0);
    drain(20);
    issue(12'h7FF, 12'h001, 1'b0);
    drain(20);

    // Random traffic with random gaps and backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) tick();
      issue(N'($urandom), N'($urandom), 1'($urandom));
    end
    begin
      int n = 0;
      while (sb.size() != 0 && n < 2000) begin
        tick();
        n++;
      end
      if (sb.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL random_drain: got %0d pending, required 0", sb.size());
      end
    end
    rand_ready = 1'b0;
    tick();
    out_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
